// File: rtl/mux_n_to_1_rr.sv
// rtl/mux_n_to_1_rr.sv - N-to-1 registered word mux with direct-select or round-robin grant.
// Optional MUXRR_STATS_EN adds a saturating output-handshake counter (xfer_count).
module mux_n_to_1_rr #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [(1<<SEL_W)*WIDTH-1:0]   in_data,
  input  logic [(1<<SEL_W)-1:0]         in_valid,
  output logic [(1<<SEL_W)-1:0]         in_ready,
  input  logic                          mode,
  input  logic [SEL_W-1:0]              sel,
  output logic [WIDTH-1:0]              out_data,
  output logic [SEL_W-1:0]              out_chan,
  output logic                          out_valid,
  input  logic                          out_ready
`ifdef MUXRR_STATS_EN
  ,
  output logic [15:0]                   xfer_count
`endif
);

  localparam int CHANNELS = 1 << SEL_W;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] scan_idx;
  logic             grant_ok;
  logic             load_en;
  logic             accept;

  assign load_en = !out_valid_q || out_ready;
  assign accept  = load_en && grant_ok;

  // Round-robin scan runs from farthest to nearest offset so the last hit,
  // i.e. the channel closest to rr_ptr, is the one that sticks.
  always_comb begin
    grant    = sel;
    grant_ok = 1'b0;
    scan_idx = rr_ptr_q;
    if (!mode) begin
      grant_ok = in_valid[sel];
    end else begin
      grant = rr_ptr_q;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        scan_idx = rr_ptr_q + SEL_W'(k);
        if (in_valid[scan_idx]) begin
          grant    = scan_idx;
          grant_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && accept) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      if (grant_ok) begin
        out_data_d  = in_data[grant*WIDTH +: WIDTH];
        out_chan_d  = grant;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    if (accept && mode) begin
      rr_ptr_d = grant + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

`ifdef MUXRR_STATS_EN
  logic [15:0] xfer_count_q, xfer_count_d;

  always_comb begin
    xfer_count_d = xfer_count_q;
    if (out_valid_q && out_ready && (xfer_count_q != 16'hFFFF)) begin
      xfer_count_d = xfer_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_count_q <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_mux_n_to_1_rr.sv
// tb/tb_mux_n_to_1_rr.sv - scoreboard bench for mux_n_to_1_rr with a queue-based reference model.
module tb_mux_n_to_1_rr;

  localparam int WIDTH = 32;
  localparam int SEL_W = 2;
  localparam int CH    = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH*WIDTH-1:0] in_data;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready;
  logic              mode;
  logic [SEL_W-1:0]  sel;
  logic [WIDTH-1:0]  out_data;
  logic [SEL_W-1:0]  out_chan;
  logic              out_valid;
  logic              out_ready;
`ifdef MUXRR_STATS_EN
  logic [15:0]       xfer_count;
`endif

  always #5 clk = ~clk;

  mux_n_to_1_rr #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUXRR_STATS_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    int               c;
  } word_t;

  word_t sb[$];
  int    grant_log[$];
  int    pass_cnt  = 0;
  int    total_cnt = 0;
  int    rr_model  = 0;
  int    exp_xfer  = 0;
  bit    mon_en    = 0;
  bit    pend      = 0;
  word_t pend_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [CH*WIDTH-1:0] rand_words();
    logic [CH*WIDTH-1:0] w;
    for (int i = 0; i < CH; i++) w[i*WIDTH +: WIDTH] = $urandom;
    return w;
  endfunction

  // One cycle of stimulus; the model decides which channel should be accepted.
  task automatic step(input logic m, input logic [SEL_W-1:0] s, input logic [CH-1:0] v,
                      input logic r, input logic [CH*WIDTH-1:0] d);
    int          g;
    bit          can_load;
    logic [CH-1:0] exp_ir;
    @(posedge clk);
    if (pend) sb.push_back(pend_w);
    pend = 0;
    #1;
    mode = m; sel = s; in_valid = v; out_ready = r; in_data = d;
    #1;
    can_load = (sb.size() == 0) || r;
    g = -1;
    if (!m) begin
      if (v[s]) g = int'(s);
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (g < 0 && v[(rr_model + k) % CH]) g = (rr_model + k) % CH;
      end
    end
    exp_ir = '0;
    if (can_load && g >= 0) begin
      exp_ir[g]  = 1'b1;
      pend       = 1;
      pend_w.d   = d[g*WIDTH +: WIDTH];
      pend_w.c   = g;
      grant_log.push_back(g);
      if (m) rr_model = (g + 1) % CH;
    end
    check("in_ready", in_ready, exp_ir);
  endtask

  // Monitor: compares the presented output word against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("out_valid", out_valid, sb.size() != 0);
        if (sb.size() != 0) begin
          check("out_data", out_data, sb[0].d);
          check("out_chan", out_chan, sb[0].c);
        end
`ifdef MUXRR_STATS_EN
        check("xfer_count", xfer_count, exp_xfer);
`endif
        if (sb.size() != 0 && out_ready) begin
          void'(sb.pop_front());
          if (exp_xfer < 16'hFFFF) exp_xfer++;
        end
      end
    end
  end

  initial begin
    int exp_rr4[6] = '{0, 1, 2, 3, 0, 1};
    int exp_rr5[4] = '{3, 1, 3, 1};
    logic [CH*WIDTH-1:0] d;

    rst_n = 1'b0; in_valid = '1; out_ready = 1'b1; mode = 1'b1; sel = '0;
    in_data = rand_words();
    #1;
    check("reset_in_ready_pre", in_ready, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_in_ready", in_ready, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_out_chan", out_chan, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = '0; mon_en = 1;

    // Round-robin from reset, all channels valid
    grant_log.delete();
    for (int i = 0; i < 6; i++) step(1'b1, 2'd0, 4'b1111, 1'b1, rand_words());
    for (int i = 0; i < 6; i++) check("rr_all_seq", grant_log[i], exp_rr4[i]);

    // Sparse round-robin starting from rr_ptr=2
    grant_log.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 4'b1010, 1'b1, rand_words());
    for (int i = 0; i < 4; i++) check("rr_sparse_seq", grant_log[i], exp_rr5[i]);

    // Direct select, then an unselected-but-valid pattern
    d = rand_words();
    d[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
    step(1'b0, 2'd2, 4'b0100, 1'b1, d);
    step(1'b0, 2'd1, 4'b1101, 1'b1, rand_words());
    step(1'b0, 2'd1, 4'b1101, 1'b1, rand_words());

    // Backpressure: hold a word for 3 cycles, then drain and reload on the same edge
    d = rand_words();
    d[0 +: WIDTH] = 32'h12345678;
    step(1'b0, 2'd0, 4'b0001, 1'b1, d);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 4'b1111, 1'b0, rand_words());
    step(1'b1, 2'd0, 4'b1111, 1'b1, rand_words());
    step(1'b1, 2'd0, 4'b0000, 1'b1, rand_words());

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, CH - 1)),
           4'($urandom), ($urandom_range(0, 9) < 7), rand_words());
    end

    step(1'b0, 2'd0, 4'b0000, 1'b1, rand_words());
    step(1'b0, 2'd0, 4'b0000, 1'b1, rand_words());
    @(negedge clk);
    @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
